// File: rtl/enc_stream_packer.sv
// -----------------------------------------------------------------------------
// enc_stream_packer
//
// Packs turbo-encoder beats (xk, zk, zk_prime) into OUT_W-bit words, first
// packed bit at the MSB, and buffers them in a first-word-fall-through FIFO.
// A block is K+4 beats: K data beats then 4 trellis-termination beats.
//   mode 0 : every beat contributes xk, zk, zk_prime
//   mode 1 : data beat n contributes xk + (n even ? zk : zk_prime);
//            tail beats contribute all three bits
// A trailing partial word is zero-padded at the LSB end during a one-cycle
// FLUSH state and tagged out_last.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   in_valid/in_ready beat handshake; in_start marks the first beat of a block
//   in_blocksize      K select sampled with in_start (0 = 1056, 1 = 6144)
//   mode              packing mode sampled with in_start
//   xk, zk, zk_prime  encoder bits of the beat
//   out_data/valid/last/ready  output word stream (FWFT)
//   fifo_level        words held in the output FIFO
//   blk_done          one-cycle pulse after a last word is written
//   err_clr           synchronous clear of the sticky error flags
//   err_orphan        beat without in_start arrived while idle
//   err_restart       in_start arrived in the middle of a block
// -----------------------------------------------------------------------------
module enc_stream_packer #(
    parameter int OUT_W = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_start,
    input  logic                       in_blocksize,
    input  logic                       mode,
    input  logic                       xk,
    input  logic                       zk,
    input  logic                       zk_prime,
    output logic                       in_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       blk_done,
    input  logic                       err_clr,
    output logic                       err_orphan,
    output logic                       err_restart
);

    localparam int RES_W = $clog2(OUT_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int EXT_W = OUT_W + 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [12:0] K_SHORT = 13'd1056;
    localparam logic [12:0] K_LONG  = 13'd6144;

    // ---------------------------------------------------------------- state
    logic [1:0]       state;
    logic [12:0]      beat_cnt;   // index of the next beat within the block
    logic [RES_W-1:0] res_cnt;    // residual bits held in acc
    logic [OUT_W-1:0] acc;        // residual bits, right-aligned
    logic             mode_q;
    logic             big_q;

    // ------------------------------------------------------ beat decode
    logic             accept;
    logic             start_beat;
    logic             data_beat;
    logic             use_beat;
    logic             orphan_ev;
    logic             restart_ev;
    logic             eff_mode;
    logic             eff_big;
    logic [12:0]      eff_idx;
    logic [12:0]      eff_k;
    logic [RES_W-1:0] eff_res;
    logic [OUT_W-1:0] eff_acc;
    logic             is_tail;
    logic             is_final;

    assign accept     = in_valid & in_ready;
    // in_ready is low in FLUSH, so an accepted start beat is always legal
    assign start_beat = accept & in_start;
    assign data_beat  = accept & ~in_start & (state == S_RUN);
    assign orphan_ev  = accept & ~in_start & (state == S_IDLE);
    assign restart_ev = start_beat & (state == S_RUN);
    assign use_beat   = start_beat | data_beat;

    // A start beat sees freshly cleared counters and the newly sampled
    // block parameters; this is also how a restart drops stale residue.
    assign eff_mode = start_beat ? mode         : mode_q;
    assign eff_big  = start_beat ? in_blocksize : big_q;
    assign eff_idx  = start_beat ? 13'd0        : beat_cnt;
    assign eff_res  = start_beat ? '0           : res_cnt;
    assign eff_acc  = start_beat ? '0           : acc;
    assign eff_k    = eff_big ? K_LONG : K_SHORT;
    assign is_tail  = eff_idx >= eff_k;
    assign is_final = eff_idx == (eff_k + 13'd3);

    logic [1:0] nbits;
    logic [2:0] new_bits;   // bits of this beat, right-aligned, oldest first

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        nbits    = 2'd3;
        new_bits = {xk, zk, zk_prime};
        if (eff_mode && !is_tail) begin
            nbits    = 2'd2;
            new_bits = {1'b0, xk, (eff_idx[0] ? zk_prime : zk)};
        end
    end

    // ----------------------------------------------------- bit packing
    // Residual and new bits are concatenated into ext; at most one word can
    // complete per beat because a beat carries at most 3 <= OUT_W bits.
    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] res_mask;
    logic [5:0]       total;
    logic [5:0]       spill;
    logic [5:0]       new_res6;
    logic [5:0]       pad_sh;
    logic             word_done;
    logic [OUT_W-1:0] beat_word;
    logic [OUT_W-1:0] acc_next;
    logic [OUT_W-1:0] flush_word;

    assign ext        = (EXT_W'(eff_acc) << nbits) | EXT_W'(new_bits);
    assign total      = 6'(eff_res) + 6'(nbits);
    assign word_done  = total >= 6'(OUT_W);
    assign spill      = total - 6'(OUT_W);
    assign new_res6   = word_done ? spill : total;
    assign beat_word  = OUT_W'(ext >> spill);
    assign res_mask   = (EXT_W'(1) << new_res6) - EXT_W'(1);
    assign acc_next   = OUT_W'(ext & res_mask);
    assign pad_sh     = 6'(OUT_W) - 6'(res_cnt);
    assign flush_word = acc << pad_sh;

    // ------------------------------------------------------- FIFO write
    logic             push;
    logic             push_last;
    logic             do_push;
    logic             pop;
    logic [OUT_W-1:0] push_data;

    assign push      = (state == S_FLUSH) | (use_beat & word_done);
    assign push_data = (state == S_FLUSH) ? flush_word : beat_word;
    assign push_last = (state == S_FLUSH) | (use_beat & is_final & (new_res6 == 6'd0));
    assign pop       = out_ready & out_valid;
    assign do_push   = push & ((fifo_level != LVL_W'(DEPTH)) | pop);

    assign in_ready  = (state != S_FLUSH) & (fifo_level <= LVL_W'(DEPTH - 2));
    assign out_valid = fifo_level != '0;

    // ------------------------------------------------------------ FSM
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            res_cnt  <= '0;
            acc      <= '0;
            mode_q   <= 1'b0;
            big_q    <= 1'b0;
        end else begin
            if (use_beat) begin
                beat_cnt <= eff_idx + 13'd1;
                res_cnt  <= RES_W'(new_res6);
                acc      <= acc_next;
                mode_q   <= eff_mode;
                big_q    <= eff_big;
            end
            case (state)
                S_IDLE: begin
                    if (start_beat) state <= S_RUN;
                end
                S_RUN: begin
                    if (data_beat && is_final)
                        state <= (new_res6 == 6'd0) ? S_IDLE : S_FLUSH;
                end
                S_FLUSH: begin
                    state   <= S_IDLE;
                    res_cnt <= '0;
                    acc     <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------ status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_done    <= 1'b0;
            err_orphan  <= 1'b0;
            err_restart <= 1'b0;
        end else begin
            blk_done    <= do_push & push_last;
            // a new event wins over a simultaneous clear
            err_orphan  <= orphan_ev  | (err_orphan  & ~err_clr);
            err_restart <= restart_ev | (err_restart & ~err_clr);
        end
    end

    // ------------------------------------------------------------ FIFO
    logic [OUT_W:0]   mem [DEPTH];   // {last, data}
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OUT_W:0]   rd_entry;

    // NOTE: the storage array has no reset; reads are gated by fifo_level,
    // so stale contents are never visible and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_last, push_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign rd_entry = mem[rd_ptr];
    assign out_data = out_valid ? rd_entry[OUT_W-1:0] : '0;
    assign out_last = out_valid & rd_entry[OUT_W];

endmodule

// File: tb/tb_enc_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_enc_stream_packer
//
// Randomized bench for enc_stream_packer. A bit-queue model appends each
// accepted beat's bits, cuts words of OUT_W bits, and keeps the expected FIFO
// contents as a queue; every cycle the DUT outputs are compared with it.
// Literal word counts and first/last words pin the model itself.
// -----------------------------------------------------------------------------
module tb_enc_stream_packer;

    localparam int OUT_W = 8;
    localparam int DEPTH = 16;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_start;
    logic             in_blocksize;
    logic             mode;
    logic             xk;
    logic             zk;
    logic             zk_prime;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic [LVL_W-1:0] fifo_level;
    logic             blk_done;
    logic             err_clr;
    logic             err_orphan;
    logic             err_restart;

    enc_stream_packer #(.OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_start     (in_start),
        .in_blocksize (in_blocksize),
        .mode         (mode),
        .xk           (xk),
        .zk           (zk),
        .zk_prime     (zk_prime),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .blk_done     (blk_done),
        .err_clr      (err_clr),
        .err_orphan   (err_orphan),
        .err_restart  (err_restart)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks  = 0;
    int n_errors  = 0;
    int ready_pct = 100;

    // behavioural model
    bit             m_in_blk;
    bit             m_flush;
    bit             m_mode;
    bit             m_done;
    bit             m_orphan;
    bit             m_restart;
    int             m_k;
    int             m_idx;
    bit             q_bits[$];
    logic [OUT_W:0] exp_q[$];   // {last, data}, front = FIFO head

    // observations of the popped stream
    int             words_in_blk;
    int             last_count;
    int             n_last;
    int             n_done;
    logic [OUT_W-1:0] first_word;
    logic [OUT_W-1:0] last_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [OUT_W-1:0] take_word();
        logic [OUT_W-1:0] w;
        w = '0;
        for (int j = 0; j < OUT_W; j++) begin
            w = w << 1;
            if (q_bits.size() > 0) w[0] = q_bits.pop_front();
        end
        return w;
    endfunction

    task automatic model_clear();
        m_in_blk     = 0;
        m_flush      = 0;
        m_done       = 0;
        m_orphan     = 0;
        m_restart    = 0;
        m_idx        = 0;
        words_in_blk = 0;
        q_bits.delete();
        exp_q.delete();
    endtask

    // Effect of the coming rising edge, from the current (stable) inputs.
    task automatic model_step();
        bit pop_now, rdy_now, acc_now, use_b, fin, have_push, lst;
        logic [OUT_W:0]   push_w;
        logic [OUT_W-1:0] w;
        pop_now   = out_ready && exp_q.size() > 0;
        rdy_now   = !m_flush && exp_q.size() <= DEPTH - 2;
        acc_now   = in_valid && rdy_now;
        have_push = 0;
        push_w    = '0;
        m_done    = 0;
        if (err_clr) begin
            m_orphan  = 0;
            m_restart = 0;
        end
        if (m_flush) begin
            w         = take_word();
            push_w    = {1'b1, w};
            have_push = 1;
            m_flush   = 0;
            m_in_blk  = 0;
            m_done    = 1;
        end else if (acc_now) begin
            use_b = 1;
            if (in_start) begin
                if (m_in_blk) m_restart = 1;
                q_bits.delete();
                m_in_blk = 1;
                m_mode   = mode;
                m_k      = in_blocksize ? 6144 : 1056;
                m_idx    = 0;
            end else if (!m_in_blk) begin
                m_orphan = 1;
                use_b    = 0;
            end
            if (use_b) begin
                q_bits.push_back(xk);
                if (m_mode && m_idx < m_k) begin
                    q_bits.push_back((m_idx % 2 == 0) ? zk : zk_prime);
                end else begin
                    q_bits.push_back(zk);
                    q_bits.push_back(zk_prime);
                end
                fin = (m_idx == m_k + 3);
                m_idx++;
                if (q_bits.size() >= OUT_W) begin
                    w         = take_word();
                    lst       = fin && (q_bits.size() == 0);
                    push_w    = {lst, w};
                    have_push = 1;
                end
                if (fin) begin
                    if (q_bits.size() == 0) begin
                        m_in_blk = 0;
                        m_done   = 1;
                    end else begin
                        m_flush = 1;
                    end
                end
            end
        end
        if (pop_now) void'(exp_q.pop_front());
        if (have_push) exp_q.push_back(push_w);
    endtask

    task automatic compare_outputs();
        int             lvl;
        logic [OUT_W:0] head;
        lvl = exp_q.size();
        check("out_valid",   out_valid,   lvl > 0);
        check("fifo_level",  fifo_level,  lvl);
        check("in_ready",    in_ready,    !m_flush && lvl <= DEPTH - 2);
        check("blk_done",    blk_done,    m_done);
        check("err_orphan",  err_orphan,  m_orphan);
        check("err_restart", err_restart, m_restart);
        if (lvl > 0) begin
            head = exp_q[0];
            check("out_data", out_data, head[OUT_W-1:0]);
            check("out_last", out_last, head[OUT_W]);
        end
    endtask

    task automatic observe();
        if (blk_done) n_done++;
        if (out_valid && out_ready) begin
            if (words_in_blk == 0) first_word = out_data;
            words_in_blk++;
            if (out_last) begin
                last_count   = words_in_blk;
                last_word    = out_data;
                n_last++;
                words_in_blk = 0;
            end
        end
    endtask

    // Single compare/model process; inputs only change just after posedge.
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_out_valid",   out_valid,   0);
            check("rst_out_last",    out_last,    0);
            check("rst_blk_done",    blk_done,    0);
            check("rst_err_orphan",  err_orphan,  0);
            check("rst_err_restart", err_restart, 0);
            check("rst_out_data",    out_data,    0);
            check("rst_fifo_level",  fifo_level,  0);
            check("rst_in_ready",    in_ready,    1);
            model_clear();
        end else begin
            compare_outputs();
            observe();
            model_step();
        end
    end

    // consumer
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    task automatic drive_beat(input bit st, input bit m, input bit big,
                              input bit x, input bit z, input bit zp, input int vpct);
        bit done;
        int guard;
        done  = 0;
        guard = 0;
        while (!done && guard < 2000) begin
            in_valid     = ($urandom_range(99) < vpct);
            in_start     = st;
            mode         = m;
            in_blocksize = big;
            xk           = x;
            zk           = z;
            zk_prime     = zp;
            @(negedge clk);
            done = in_valid && in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        in_start = 1'b0;
        if (!done) timeout("beat_accept");
    endtask

    task automatic send_block(input bit m, input bit big, input int nbeats,
                              input bit fixed_bits, input int vpct);
        logic [2:0] b;
        for (int i = 0; i < nbeats; i++) begin
            if (fixed_bits) b = 3'b101;
            else            b = 3'($urandom_range(7));
            drive_beat(i == 0, m, big, b[2], b[1], b[0], vpct);
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || m_flush || out_valid) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) timeout("drain");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    int base_last;
    int base_done;

    initial begin
        reset        = 1'b0;
        in_valid     = 1'b0;
        in_start     = 1'b0;
        in_blocksize = 1'b0;
        mode         = 1'b0;
        xk           = 1'b0;
        zk           = 1'b0;
        zk_prime     = 1'b0;
        err_clr      = 1'b0;
        n_last       = 0;
        n_done       = 0;
        last_count   = 0;
        first_word   = '0;
        last_word    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // mode 0, K=1056, constant 1,0,1 bits
        base_last = n_last; base_done = n_done;
        send_block(1'b0, 1'b0, 1060, 1'b1, 100);
        wait_drain();
        check("m0k1056_words", last_count, 398);
        check("m0k1056_first", first_word, 8'hB6);
        check("m0k1056_last",  last_word,  8'hD0);
        check("m0k1056_nlast", n_last - base_last, 1);
        check("m0k1056_done",  n_done - base_done, 1);

        // mode 1, K=1056, constant bits: puncturing gives 1011 per beat pair
        base_last = n_last; base_done = n_done;
        send_block(1'b1, 1'b0, 1060, 1'b1, 100);
        wait_drain();
        check("m1k1056_words", last_count, 266);
        check("m1k1056_first", first_word, 8'hBB);
        check("m1k1056_last",  last_word,  8'hD0);
        check("m1k1056_done",  n_done - base_done, 1);

        // mode 0, K=6144, random bits and handshakes
        ready_pct = 60;
        base_last = n_last; base_done = n_done;
        send_block(1'b0, 1'b1, 6148, 1'b0, 80);
        wait_drain();
        check("m0k6144_words", last_count, 2306);
        check("m0k6144_pad",   last_word & 8'h0F, 0);
        check("m0k6144_nlast", n_last - base_last, 1);
        check("m0k6144_done",  n_done - base_done, 1);

        // back-pressure: consumer stalled until in_ready drops
        ready_pct = 0;
        @(posedge clk);
        #2;
        base_last = n_last; base_done = n_done;
        fork
            send_block(1'b1, 1'b0, 1060, 1'b0, 100);
            begin
                int guard;
                guard = 0;
                @(negedge clk);
                while (in_ready && guard < 1000) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 1000) timeout("stall_in_ready");
                check("stall_level", fifo_level, DEPTH - 1);
                repeat (20) @(negedge clk);
                check("stall_hold_level", fifo_level, DEPTH - 1);
                check("stall_hold_ready", in_ready, 0);
                ready_pct = 100;
            end
        join
        wait_drain();
        check("stall_words", last_count, 266);
        check("stall_done",  n_done - base_done, 1);

        // restart at beat 500: 187 abandoned words, then a full block
        base_last = n_last; base_done = n_done;
        send_block(1'b0, 1'b0, 500, 1'b0, 100);
        send_block(1'b0, 1'b0, 1060, 1'b0, 100);
        wait_drain();
        check("restart_flag",  err_restart, 1);
        check("restart_words", last_count, 585);
        check("restart_nlast", n_last - base_last, 1);
        check("restart_done",  n_done - base_done, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("restart_clr", err_restart, 0);
        @(posedge clk);
        #1;

        // orphan beat in IDLE, then reset in the middle of a block
        drive_beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 100);
        check("orphan_flag", err_orphan, 1);
        base_last = n_last;
        send_block(1'b0, 1'b1, 300, 1'b0, 100);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_orphan", err_orphan, 0);
        check("rst_mid_level",  fifo_level, 0);
        check("rst_mid_valid",  out_valid, 0);
        check("rst_mid_ready",  in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_nlast", n_last - base_last, 0);

        // mode 1, K=6144, random
        ready_pct = 50;
        base_last = n_last; base_done = n_done;
        send_block(1'b1, 1'b1, 6148, 1'b0, 70);
        wait_drain();
        check("m1k6144_words", last_count, 1538);
        check("m1k6144_pad",   last_word & 8'h0F, 0);
        check("m1k6144_done",  n_done - base_done, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
